// File: rtl/shared_reg_arbiter_if.sv
// Bus between the load requesters and the shared-register arbiter.
//   master : requester side  (drives Req, Req_Data, Clr_Req)
//   slave  : arbiter side    (drives register strobes, grants and acks)
// Req_Data is flattened; requester i owns bits [i*W +: W].
interface shared_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic [N-1:0]   Req;
  logic [N*W-1:0] Req_Data;
  logic           Clr_Req;
  logic [W-1:0]   Reg_Data;
  logic           Reg_Ld;
  logic           Reg_Init;
  logic [N-1:0]   Gnt;
  logic [N-1:0]   Ack;
  logic           Clr_Ack;
  logic           Busy;

  modport master (
    output Req, Req_Data, Clr_Req,
    input  Reg_Data, Reg_Ld, Reg_Init, Gnt, Ack, Clr_Ack, Busy
  );

  modport slave (
    input  Req, Req_Data, Clr_Req,
    output Reg_Data, Reg_Ld, Reg_Init, Gnt, Ack, Clr_Ack, Busy
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter / load sequencer for one shared Ld/Init data register.
// Each transaction is IDLE -> LOAD|CLEAR -> DONE -> IDLE (3 cycles).
// Ports:
//   Clk  : system clock, rising edge
//   Rst  : asynchronous active-low reset
//   bus  : slave side of shared_reg_arbiter_if
//          in : Req[N], Req_Data[N*W], Clr_Req
//          out: Reg_Data[W] (registered), Reg_Ld, Reg_Init, Gnt[N], Ack[N],
//               Clr_Ack, Busy
module shared_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  shared_reg_arbiter_if.slave   bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  last;      // most recent winner; search starts at last+1
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  cand;
  logic           win_vld;
  logic [N-1:0]   gnt;
  logic [W-1:0]   data_q;
  logic           clr_q;     // current transaction is a clear

  // unflatten request data so the winner's slice is a plain array select
  logic [W-1:0] slice [N];
  for (genvar g = 0; g < N; g++) begin : g_slice
    assign slice[g] = bus.Req_Data[g*W +: W];
  end

  // first set Req scanning last+1, last+2, ... (mod N)
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!win_vld && bus.Req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.Clr_Req)  state_nxt = CLEAR;
             else if (win_vld) state_nxt = LOAD;
      LOAD:  state_nxt = DONE;
      CLEAR: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      last   <= IW'(N-1);
      gnt    <= '0;
      data_q <= '0;
      clr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          // clear wins outright; pointer and data untouched by a clear
          if (bus.Clr_Req) begin
            clr_q <= 1'b1;
          end else if (win_vld) begin
            clr_q  <= 1'b0;
            last   <= win_idx;
            data_q <= slice[win_idx];
            gnt    <= N'(1) << win_idx;
          end
        end
        DONE:    gnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.Reg_Data = data_q;
  assign bus.Reg_Ld   = (state == LOAD);
  assign bus.Reg_Init = (state == CLEAR);
  assign bus.Gnt      = gnt;
  assign bus.Ack      = (state == DONE && !clr_q) ? gnt : '0;
  assign bus.Clr_Ack  = (state == DONE) && clr_q;
  assign bus.Busy     = (state != IDLE);
endmodule
